// File: rtl/easyaxi_wr_slv.sv
// AXI write-channel responder: one burst at a time into a word-addressed register memory.
// Optional feature macro EASYAXI_WR_WSTRB_EN: honour byte strobes (otherwise full-word writes).
`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif

module easyaxi_wr_slv #(
    parameter int                     MEM_DEPTH = 64,
    parameter logic [`AXI_ADDR_W-1:0] MEM_BASE  = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         axi_slv_awvalid,
    output logic                         axi_slv_awready,
    input  logic [`AXI_ID_W-1:0]         axi_slv_awid,
    input  logic [`AXI_ADDR_W-1:0]       axi_slv_awaddr,
    input  logic [`AXI_LEN_W-1:0]        axi_slv_awlen,
    input  logic [`AXI_SIZE_W-1:0]       axi_slv_awsize,
    input  logic [`AXI_BURST_W-1:0]      axi_slv_awburst,
    input  logic                         axi_slv_wvalid,
    output logic                         axi_slv_wready,
    input  logic [`AXI_DATA_W-1:0]       axi_slv_wdata,
    input  logic [`AXI_DATA_W/8-1:0]     axi_slv_wstrb,
    input  logic                         axi_slv_wlast,
    output logic                         axi_slv_bvalid,
    input  logic                         axi_slv_bready,
    output logic [`AXI_ID_W-1:0]         axi_slv_bid,
    output logic [`AXI_RESP_W-1:0]       axi_slv_bresp,
    input  logic [$clog2(MEM_DEPTH)-1:0] dbg_idx,
    output logic [`AXI_DATA_W-1:0]       dbg_data
);

    localparam int AW         = `AXI_ADDR_W;
    localparam int DW         = `AXI_DATA_W;
    localparam int BYTES      = DW / 8;
    localparam int BYTE_SHIFT = $clog2(BYTES);
    localparam int IDX_W      = $clog2(MEM_DEPTH);
    localparam logic [AW:0] MEM_LIMIT = {1'b0, MEM_BASE} + (AW+1)'(MEM_DEPTH * BYTES);
    localparam logic [`AXI_BURST_W-1:0] BURST_INCR = `AXI_BURST_W'(1);
    localparam logic [`AXI_RESP_W-1:0]  RESP_OKAY  = `AXI_RESP_W'(0);
    localparam logic [`AXI_RESP_W-1:0]  RESP_SLV   = `AXI_RESP_W'(2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                    state_r, state_nxt_s;
    logic                      run_r;
    logic [`AXI_ID_W-1:0]      id_r;
    logic [AW-1:0]             addr_r;
    logic [`AXI_LEN_W-1:0]     len_r, cnt_r;
    logic [`AXI_SIZE_W-1:0]    size_r;
    logic [`AXI_BURST_W-1:0]   burst_r;
    logic                      err_r, wrap_r;
    logic [DW-1:0]             mem_r [MEM_DEPTH];

    logic                      aw_hs_s, w_hs_s, b_hs_s, last_s;
    logic                      illegal_s, in_range_s, beat_err_s, wr_en_s, carry_s;
    logic [AW-1:0]             step_s, addr_nxt_s, off_s;
    logic [IDX_W-1:0]          idx_s;
    logic [BYTES-1:0]          strb_s;

    assign axi_slv_awready = run_r && (state_r == S_IDLE) && enable;
    assign axi_slv_wready  = (state_r == S_DATA);
    assign axi_slv_bvalid  = (state_r == S_RESP);
    assign axi_slv_bid     = id_r;
    assign axi_slv_bresp   = (state_r == S_RESP && err_r) ? RESP_SLV : RESP_OKAY;
    assign dbg_data        = mem_r[dbg_idx];

    assign aw_hs_s = axi_slv_awvalid && axi_slv_awready;
    assign w_hs_s  = axi_slv_wvalid && axi_slv_wready;
    assign b_hs_s  = axi_slv_bvalid && axi_slv_bready;

    // Per-beat address decode, legality and error classification.
    always_comb begin
        last_s     = (cnt_r == len_r);
        illegal_s  = burst_r[1] || (size_r > `AXI_SIZE_W'(BYTE_SHIFT));
        in_range_s = !wrap_r && (addr_r >= MEM_BASE) && ({1'b0, addr_r} < MEM_LIMIT);
        off_s      = addr_r - MEM_BASE;
        idx_s      = off_s[BYTE_SHIFT +: IDX_W];
        step_s     = {{(AW-1){1'b0}}, 1'b1} << size_r;
        {carry_s, addr_nxt_s} = {1'b0, addr_r} + {1'b0, step_s};
        beat_err_s = illegal_s || !in_range_s || (axi_slv_wlast != last_s);
        wr_en_s    = w_hs_s && !illegal_s && in_range_s;
`ifdef EASYAXI_WR_WSTRB_EN
        strb_s     = axi_slv_wstrb;
`else
        // Strobes are ignored; OR with the port keeps it tied into the logic.
        strb_s     = {BYTES{1'b1}} | axi_slv_wstrb;
`endif
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE:  if (aw_hs_s)           state_nxt_s = S_DATA; else state_nxt_s = S_IDLE;
            S_DATA:  if (w_hs_s && last_s)  state_nxt_s = S_RESP; else state_nxt_s = S_DATA;
            S_RESP:  if (b_hs_s)            state_nxt_s = S_IDLE; else state_nxt_s = S_RESP;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // State register; run_r keeps awready low until the first clock after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            run_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            run_r   <= 1'b1;
        end
    end

    // Burst context: latched on AW, advanced on each accepted W beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_r    <= '0;
            addr_r  <= '0;
            len_r   <= '0;
            size_r  <= '0;
            burst_r <= '0;
            cnt_r   <= '0;
            err_r   <= 1'b0;
            wrap_r  <= 1'b0;
        end else if (aw_hs_s) begin
            id_r    <= axi_slv_awid;
            addr_r  <= axi_slv_awaddr;
            len_r   <= axi_slv_awlen;
            size_r  <= axi_slv_awsize;
            burst_r <= axi_slv_awburst;
            cnt_r   <= '0;
            err_r   <= 1'b0;
            wrap_r  <= 1'b0;
        end else if (w_hs_s) begin
            cnt_r <= cnt_r + `AXI_LEN_W'(1);
            err_r <= err_r || beat_err_s;
            if (burst_r == BURST_INCR) begin
                addr_r <= addr_nxt_s;
                wrap_r <= wrap_r || carry_s;
            end else begin
                addr_r <= addr_r;
                wrap_r <= wrap_r;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Register memory with byte-lane writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem_r[i] <= '0;
        end else if (wr_en_s) begin
            for (int b = 0; b < BYTES; b++) begin
                if (strb_s[b]) mem_r[idx_s][8*b +: 8] <= axi_slv_wdata[8*b +: 8];
            end
        end else begin
            mem_r <= mem_r;
        end
    end

endmodule

// File: tb/tb_easyaxi_wr_slv.sv
// Directed self-checking bench for easyaxi_wr_slv (32-bit data/address, 64-word memory at base 0).
`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif

module tb_easyaxi_wr_slv;

    logic                     clk = 1'b0;
    logic                     rst_n, enable;
    logic                     awvalid, awready;
    logic [`AXI_ID_W-1:0]     awid;
    logic [`AXI_ADDR_W-1:0]   awaddr;
    logic [`AXI_LEN_W-1:0]    awlen;
    logic [`AXI_SIZE_W-1:0]   awsize;
    logic [`AXI_BURST_W-1:0]  awburst;
    logic                     wvalid, wready, wlast;
    logic [`AXI_DATA_W-1:0]   wdata;
    logic [`AXI_DATA_W/8-1:0] wstrb;
    logic                     bvalid, bready;
    logic [`AXI_ID_W-1:0]     bid;
    logic [`AXI_RESP_W-1:0]   bresp;
    logic [5:0]               dbg_idx;
    logic [`AXI_DATA_W-1:0]   dbg_data;

    int checks = 0;
    int errors = 0;
    logic [31:0] w0_exp;

    always #5 clk = ~clk;

    easyaxi_wr_slv #(.MEM_DEPTH(64), .MEM_BASE(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .axi_slv_awvalid(awvalid), .axi_slv_awready(awready), .axi_slv_awid(awid),
        .axi_slv_awaddr(awaddr), .axi_slv_awlen(awlen), .axi_slv_awsize(awsize),
        .axi_slv_awburst(awburst), .axi_slv_wvalid(wvalid), .axi_slv_wready(wready),
        .axi_slv_wdata(wdata), .axi_slv_wstrb(wstrb), .axi_slv_wlast(wlast),
        .axi_slv_bvalid(bvalid), .axi_slv_bready(bready), .axi_slv_bid(bid),
        .axi_slv_bresp(bresp), .dbg_idx(dbg_idx), .dbg_data(dbg_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic peek(input string tag, input logic [5:0] idx, input logic [31:0] exp);
        dbg_idx = idx;
        #1;
        check(tag, dbg_data, exp);
    endtask

    task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        int n;
        awvalid = 1'b1; awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
        n = 0;
        while (!awready && n < 20) begin @(negedge clk); n++; end
        check("aw_ready_wait", {31'd0, awready}, 32'd1);
        @(posedge clk); @(negedge clk);
        awvalid = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int n;
        wvalid = 1'b1; wdata = data; wstrb = strb; wlast = last;
        n = 0;
        while (!wready && n < 20) begin @(negedge clk); n++; end
        check("w_ready_wait", {31'd0, wready}, 32'd1);
        @(posedge clk); @(negedge clk);
        wvalid = 1'b0;
    endtask

    task automatic do_b(input logic [3:0] exp_id, input logic [1:0] exp_resp);
        int n;
        bready = 1'b1;
        n = 0;
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        check("b_valid_wait", {31'd0, bvalid}, 32'd1);
        check("b_id", {28'd0, bid}, {28'd0, exp_id});
        check("b_resp", {30'd0, bresp}, {30'd0, exp_resp});
        @(posedge clk); @(negedge clk);
        bready = 1'b0;
        check("b_done_valid", {31'd0, bvalid}, 32'd0);
        check("b_done_awready", {31'd0, awready}, {31'd0, enable});
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; awvalid = 1'b0; awid = '0; awaddr = '0; awlen = '0;
        awsize = '0; awburst = '0; wvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0;
        bready = 1'b0; dbg_idx = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_awready", {31'd0, awready}, 32'd0);
        check("rst_wready", {31'd0, wready}, 32'd0);
        check("rst_bvalid", {31'd0, bvalid}, 32'd0);
        check("rst_bid", {28'd0, bid}, 32'd0);
        check("rst_bresp", {30'd0, bresp}, 32'd0);
        peek("rst_mem0", 6'd0, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_awready", {31'd0, awready}, 32'd1);

        // Single beat: bvalid at T+2
        do_aw(4'h3, 32'h10, 8'd0, 3'd2, 2'd1);
        check("sb_wready_t1", {31'd0, wready}, 32'd1);
        check("sb_awready_data", {31'd0, awready}, 32'd0);
        check("sb_bvalid_t1", {31'd0, bvalid}, 32'd0);
        do_w(32'hDEADBEEF, 4'hF, 1'b1);
        check("sb_bvalid_t2", {31'd0, bvalid}, 32'd1);
        peek("sb_mem4", 6'd4, 32'hDEADBEEF);
        do_b(4'h3, 2'd0);

        // INCR 4 beats, bready held low 3 cycles
        do_aw(4'h5, 32'h20, 8'd3, 3'd2, 2'd1);
        do_w(32'd1, 4'hF, 1'b0);
        do_w(32'd2, 4'hF, 1'b0);
        do_w(32'd3, 4'hF, 1'b0);
        do_w(32'd4, 4'hF, 1'b1);
        for (int k = 0; k < 3; k++) begin
            check("incr_hold_bvalid", {31'd0, bvalid}, 32'd1);
            check("incr_hold_bid", {28'd0, bid}, 32'd5);
            check("incr_hold_bresp", {30'd0, bresp}, 32'd0);
            @(negedge clk);
        end
        do_b(4'h5, 2'd0);
        for (int k = 0; k < 4; k++) peek("incr_mem", 6'(8 + k), 32'(k + 1));

        // Byte strobes on word 0
        do_aw(4'h1, 32'h0, 8'd0, 3'd2, 2'd1);
        do_w(32'hFFFFFFFF, 4'hF, 1'b1);
        do_b(4'h1, 2'd0);
        do_aw(4'h2, 32'h0, 8'd0, 3'd2, 2'd1);
        do_w(32'h00000000, 4'h5, 1'b1);
        do_b(4'h2, 2'd0);
`ifdef EASYAXI_WR_WSTRB_EN
        w0_exp = 32'hFF00FF00;
`else
        w0_exp = 32'h00000000;
`endif
        peek("strb_mem0", 6'd0, w0_exp);

        // Out of range: second beat at 0x100 dropped
        do_aw(4'h6, 32'hFC, 8'd1, 3'd2, 2'd1);
        do_w(32'hA5A5A5A5, 4'hF, 1'b0);
        do_w(32'h5A5A5A5A, 4'hF, 1'b1);
        do_b(4'h6, 2'd2);
        peek("oor_mem63", 6'd63, 32'hA5A5A5A5);
        peek("oor_mem0", 6'd0, w0_exp);

        // WRAP burst writes nothing
        do_aw(4'h8, 32'h40, 8'd1, 3'd2, 2'd2);
        do_w(32'h11111111, 4'hF, 1'b0);
        do_w(32'h22222222, 4'hF, 1'b1);
        do_b(4'h8, 2'd2);
        peek("wrap_mem16", 6'd16, 32'h0);
        peek("wrap_mem17", 6'd17, 32'h0);

        // Early wlast: both beats still written
        do_aw(4'h9, 32'h50, 8'd1, 3'd2, 2'd1);
        do_w(32'h33333333, 4'hF, 1'b1);
        do_w(32'h44444444, 4'hF, 1'b0);
        do_b(4'h9, 2'd2);
        peek("wlast_mem20", 6'd20, 32'h33333333);
        peek("wlast_mem21", 6'd21, 32'h44444444);

        // enable gating in IDLE
        @(negedge clk);
        enable = 1'b0;
        awvalid = 1'b1; awid = 4'hA; awaddr = 32'h30; awlen = 8'd0; awsize = 3'd2; awburst = 2'd1;
        #1 check("en_low_awready", {31'd0, awready}, 32'd0);
        @(negedge clk);
        check("en_low_awready2", {31'd0, awready}, 32'd0);
        enable = 1'b1;
        #1 check("en_rise_awready", {31'd0, awready}, 32'd1);
        @(posedge clk); @(negedge clk);
        awvalid = 1'b0;
        do_w(32'hCAFEF00D, 4'hF, 1'b1);
        do_b(4'hA, 2'd0);
        peek("en_mem12", 6'd12, 32'hCAFEF00D);

        // Reset mid-burst
        do_aw(4'h7, 32'h60, 8'd1, 3'd2, 2'd1);
        do_w(32'h77777777, 4'hF, 1'b0);
        peek("mid_mem24", 6'd24, 32'h77777777);
        rst_n = 1'b0;
        #1;
        check("mid_rst_awready", {31'd0, awready}, 32'd0);
        check("mid_rst_wready", {31'd0, wready}, 32'd0);
        check("mid_rst_bvalid", {31'd0, bvalid}, 32'd0);
        check("mid_rst_bid", {28'd0, bid}, 32'd0);
        check("mid_rst_bresp", {30'd0, bresp}, 32'd0);
        peek("mid_rst_mem24", 6'd24, 32'h0);
        peek("mid_rst_mem4", 6'd4, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_rst_bvalid", {31'd0, bvalid}, 32'd0);
        end
        check("post_rst_awready", {31'd0, awready}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
